// File: rtl/palette_pkg.sv
// Palette controller shared types: entry map, reset colours, FSM states.
// Latency: n/a (declarations only). Backpressure: n/a.
// Colours are packed RRR_GGG_BB; the entry map is fixed by the colorizer.
package palette_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int COLOR_W     = 8;
    localparam int IDX_W       = 3;
    localparam int PAL_W       = NUM_ENTRIES * COLOR_W;
    localparam int BLINK_DIV   = 5;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [IDX_W-1:0]   pal_idx_t;

    localparam pal_idx_t PAL_BLANK  = 3'd0;
    localparam pal_idx_t PAL_ICON1  = 3'd1;
    localparam pal_idx_t PAL_ICON2  = 3'd2;
    localparam pal_idx_t PAL_ICON3  = 3'd3;
    localparam pal_idx_t PAL_WORLD0 = 3'd4;
    localparam pal_idx_t PAL_WORLD1 = 3'd5;
    localparam pal_idx_t PAL_WORLD2 = 3'd6;
    localparam pal_idx_t PAL_WORLD3 = 3'd7;
    localparam pal_idx_t PAL_LAST   = PAL_WORLD3;

    localparam color_t DEF_BLANK  = 8'h00;
    localparam color_t DEF_ICON1  = 8'h80;
    localparam color_t DEF_ICON2  = 8'h1F;
    localparam color_t DEF_ICON3  = 8'hE3;
    localparam color_t DEF_WORLD0 = 8'hFF;
    localparam color_t DEF_WORLD1 = 8'h00;
    localparam color_t DEF_WORLD2 = 8'hE0;
    localparam color_t DEF_WORLD3 = 8'h92;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COPY
    } pal_state_t;

    function automatic color_t default_color(input pal_idx_t idx);
        color_t c;
        case (idx)
            PAL_BLANK:  c = DEF_BLANK;
            PAL_ICON1:  c = DEF_ICON1;
            PAL_ICON2:  c = DEF_ICON2;
            PAL_ICON3:  c = DEF_ICON3;
            PAL_WORLD0: c = DEF_WORLD0;
            PAL_WORLD1: c = DEF_WORLD1;
            PAL_WORLD2: c = DEF_WORLD2;
            PAL_WORLD3: c = DEF_WORLD3;
            default:    c = DEF_BLANK;
        endcase
        return c;
    endfunction

    function automatic logic is_icon_entry(input pal_idx_t idx);
        return (idx == PAL_ICON1) || (idx == PAL_ICON2) || (idx == PAL_ICON3);
    endfunction

endpackage

// File: rtl/palette_ctrl_if.sv
// Host-side write/commit/readback bus plus the flat palette towards the colorizer.
// Latency: n/a (wiring only). Backpressure: wr_req is held until wr_ack.
// master = host/DTG side, slave = palette_ctrl.
interface palette_ctrl_if;
    import palette_pkg::*;

    logic              wr_req;
    pal_idx_t          wr_addr;
    color_t            wr_data;
    logic              wr_ack;
    logic              commit_req;
    logic              frame_start;
    logic              commit_pending;
    logic [PAL_W-1:0]  pal_active;
    pal_idx_t          rd_addr;
    color_t            rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, commit_req, frame_start, rd_addr,
        input  wr_ack, commit_pending, pal_active, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, commit_req, frame_start, rd_addr,
        output wr_ack, commit_pending, pal_active, rd_data
    );

endinterface

// File: rtl/palette_ctrl.sv
// Shadow/active colour palette; shadow copied to active one entry per cycle after a committed vblank.
// Latency: write ack and readback 1 cycle; commit lands 8 cycles after the next frame_start.
// Backpressure: writes stall (no ack) while copying. Optional icon blink under PALETTE_BLINK_EN.
module palette_ctrl
    import palette_pkg::*;
(
    input  logic          clock,
    input  logic          rst,
    palette_ctrl_if.slave bus
);

    pal_state_t state_q, state_d;
    pal_idx_t   idx_q, idx_d;
    color_t     shadow_q [NUM_ENTRIES];
    color_t     shadow_d [NUM_ENTRIES];
    color_t     active_q [NUM_ENTRIES];
    color_t     active_d [NUM_ENTRIES];
    logic       wr_ack_q, wr_ack_d;
    color_t     rd_data_q, rd_data_d;
    logic       wr_accept;
    logic       blank_icons;

    // The ack cycle itself never accepts, so a held request gets a gap between acks.
    always_comb begin
        wr_accept = bus.wr_req && !wr_ack_q && (state_q != COPY);
    end

    always_comb begin
        shadow_d  = shadow_q;
        wr_ack_d  = 1'b0;
        rd_data_d = shadow_q[bus.rd_addr];
        if (wr_accept) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
            wr_ack_d              = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (bus.commit_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (bus.frame_start) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                active_d[idx_q] = shadow_q[idx_q];
                idx_d           = idx_q + 1'b1;
                if (idx_q == PAL_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i] <= default_color(IDX_W'(i));
                active_q[i] <= default_color(IDX_W'(i));
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_ack_q  <= wr_ack_d;
            rd_data_q <= rd_data_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

`ifdef PALETTE_BLINK_EN
    logic [BLINK_DIV:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (bus.frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign blank_icons = frame_cnt_q[BLINK_DIV];
`else
    assign blank_icons = 1'b0;
`endif

    // Blink masks only the output view; the active registers keep their colours.
    always_comb begin
        bus.pal_active = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (blank_icons && is_icon_entry(IDX_W'(i))) begin
                bus.pal_active[i*COLOR_W +: COLOR_W] = '0;
            end else begin
                bus.pal_active[i*COLOR_W +: COLOR_W] = active_q[i];
            end
        end
    end

    assign bus.wr_ack         = wr_ack_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.commit_pending = (state_q != IDLE);

endmodule

// File: tb/tb_palette_ctrl.sv
// Scoreboard bench for palette_ctrl: drivers push expectations, a negedge monitor pops and compares.
// Reference model keeps whole-palette vectors and a cycle-level copy window.
`timescale 1ns/1ps
module tb_palette_ctrl;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    palette_ctrl_if pif ();

    palette_ctrl dut (
        .clock (clock),
        .rst   (rst),
        .bus   (pif)
    );

    typedef struct {
        int          cyc;
        logic [63:0] pal;
        logic        pend;
    } pal_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } rd_exp_t;

    localparam logic [63:0] RESET_PAL = 64'h92E000FF_E31F8000;

    pal_exp_t pal_q [$];
    rd_exp_t  rd_q [$];
    int       ack_q [$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [63:0] m_shadow;
    logic [63:0] m_active;
    bit          m_pending;
    int          idle_from;

    always @(posedge clock) cyc++;

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        int       ae;
        pal_exp_t pe;
        rd_exp_t  re;
        if (mon_en) begin
            if (pif.wr_ack === 1'b1) begin
                total++;
                if (ack_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_ack_unexpected cycle=%0d got=1 want=0", cyc);
                end else begin
                    ae = ack_q.pop_front();
                    if (ae != cyc) begin
                        bad++;
                        $display("FAIL wr_ack_timing got cycle %0d want cycle %0d", cyc, ae);
                    end
                end
            end
            while (ack_q.size() > 0 && ack_q[0] < cyc) begin
                total++;
                bad++;
                $display("FAIL wr_ack_missing cycle=%0d got=0 want ack at %0d", cyc, ack_q[0]);
                void'(ack_q.pop_front());
            end
            while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                re = rd_q.pop_front();
                total++;
                if (re.cyc != cyc || pif.rd_data !== re.val) begin
                    bad++;
                    $display("FAIL rd_data cycle=%0d got=%02h want=%02h", cyc, pif.rd_data, re.val);
                end
            end
            while (pal_q.size() > 0 && pal_q[0].cyc <= cyc) begin
                pe = pal_q.pop_front();
                total += 2;
                if (pe.cyc != cyc || pif.pal_active !== pe.pal) begin
                    bad++;
                    $display("FAIL pal_active cycle=%0d got=%016h want=%016h", cyc, pif.pal_active, pe.pal);
                end
                if (pif.commit_pending !== pe.pend) begin
                    bad++;
                    $display("FAIL commit_pending cycle=%0d got=%0b want=%0b", cyc, pif.commit_pending, pe.pend);
                end
            end
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [63:0] mix(input logic [63:0] old_p, input logic [63:0] new_p, input int n);
        logic [63:0] r;
        r = old_p;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = new_p[i*8 +: 8];
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_pal(input int c, input logic [63:0] p, input logic pe);
        pal_exp_t e;
        e.cyc  = c;
        e.pal  = p;
        e.pend = pe;
        pal_q.push_back(e);
    endtask

    task automatic check_now;
        if (cyc >= idle_from) push_pal(cyc, m_active, m_pending);
    endtask

    task automatic do_read(input logic [2:0] a);
        rd_exp_t e;
        pif.rd_addr = a;
        e.cyc = cyc + 1;
        e.val = m_shadow[int'(a)*8 +: 8];
        rd_q.push_back(e);
        tick;
    endtask

    // commit is honoured only outside the copy window
    task automatic commit_model;
        pif.commit_req = 1'b1;
        if (cyc >= idle_from) begin
            m_pending = 1'b1;
            push_pal(cyc + 1, m_active, 1'b1);
        end
    endtask

    // copy window: cycles F+1..F+8 copy entries 0..7; idle again at F+9
    task automatic frame_model(input int nchk);
        pif.frame_start = 1'b1;
        if (cyc >= idle_from && m_pending) begin
            for (int j = 0; j < nchk; j++)
                push_pal(cyc + j, mix(m_active, m_shadow, (j > 1) ? j - 1 : 0), (j <= 8));
            m_active  = m_shadow;
            m_pending = 1'b0;
            idle_from = cyc + 9;
        end
    endtask

    task automatic do_commit;
        commit_model();
        tick;
        pif.commit_req = 1'b0;
    endtask

    task automatic do_frame;
        frame_model(10);
        tick;
        pif.frame_start = 1'b0;
    endtask

    task automatic do_commit_frame;
        frame_model(10);
        commit_model();
        tick;
        pif.frame_start = 1'b0;
        pif.commit_req  = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input bit with_commit);
        int acc;
        bit got;
        got         = 1'b0;
        pif.wr_req  = 1'b1;
        pif.wr_addr = a;
        pif.wr_data = d;
        acc = (cyc > idle_from) ? cyc : idle_from;
        ack_q.push_back(acc + 1);
        if (with_commit) commit_model();
        for (int k = 0; k < 40; k++) begin
            tick;
            pif.commit_req = 1'b0;
            if (pif.wr_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        pif.wr_req = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wr_ack_timeout addr=%0d got no ack want ack at cycle %0d", a, acc + 1);
        end
        m_shadow[int'(a)*8 +: 8] = d;
        tick;
    endtask

    task automatic reset_model;
        m_shadow  = RESET_PAL;
        m_active  = RESET_PAL;
        m_pending = 1'b0;
        idle_from = 0;
    endtask

    task automatic do_reset_mid_copy;
        do_write(3'd1, 8'h3C, 1'b1);
        frame_model(4);
        tick;
        pif.frame_start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        reset_model();
        check_now();
        do_read(3'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        pif.wr_req      = 1'b0;
        pif.wr_addr     = '0;
        pif.wr_data     = '0;
        pif.commit_req  = 1'b0;
        pif.frame_start = 1'b0;
        pif.rd_addr     = '0;
        reset_model();
        repeat (3) tick;
        rst    = 1'b0;
        mon_en = 1'b1;
        check_now();
        do_read(3'd0);
        do_read(3'd7);

        do_write(3'd4, 8'h1C, 1'b0);
        do_frame();
        tick;
        check_now();
        do_read(3'd4);

        do_commit();
        do_frame();
        repeat (9) tick;
        check_now();

        do_write(3'd2, 8'h55, 1'b0);
        do_commit_frame();
        repeat (2) tick;
        check_now();
        do_frame();
        repeat (9) tick;
        check_now();

        do_write(3'd5, 8'hAA, 1'b1);
        do_frame();
        tick;
        do_write(3'd6, 8'h77, 1'b0);
        check_now();
        do_read(3'd6);
        do_commit();
        do_frame();
        repeat (9) tick;
        check_now();

        do_reset_mid_copy();

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0, 1:    do_write(3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0));
                2:       do_read(3'($urandom_range(0, 7)));
                3:       do_commit();
                4:       do_frame();
                5:       do_commit_frame();
                default: begin
                    check_now();
                    tick;
                end
            endcase
        end

        repeat (12) tick;
        check_now();
        repeat (2) tick;
        if (pal_q.size() + rd_q.size() + ack_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", pal_q.size() + rd_q.size() + ack_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/palette_ctrl.md
Name: palette_ctrl

Overview:
- Programmable colour-palette controller for the Rojobot world video path.
- Holds a shadow palette written by the host (PicoBlaze I/O port side) and an active palette driven flat into the pixel colorizer.
- Copies shadow to active only during vertical blank, after a commit request, so palette updates never tear mid-frame.
- Sits between the host I/O decode and the colorizer, in the 25 MHz video clock domain.

Parameters:
- NUM_ENTRIES, 8, palette entries; fixed map: 0 = blank, 1-3 = icon colours 1-3, 4-7 = world pixel 00-11.
- COLOR_W, 8, bits per entry, packed RRR_GGG_BB.
- BLINK_DIV, 5, log2 of frames per blink half-period; used only with the optional feature.

Ports:
- clock, in, 1, 25 MHz video clock.
- rst, in, 1, synchronous active-high reset.
- wr_req, in, 1, host write request; held high until wr_ack.
- wr_addr, in, 3, shadow entry index.
- wr_data, in, 8, colour value.
- wr_ack, out, 1, one-cycle pulse; the write has been accepted.
- commit_req, in, 1, one-cycle pulse; request a shadow-to-active copy at the next vblank.
- frame_start, in, 1, one-cycle pulse at the start of vertical blank, from the DTG.
- commit_pending, out, 1, high from commit accept until the copy completes.
- pal_active, out, 64, active palette; entry i occupies bits [8i+7:8i].
- rd_addr, in, 3, shadow readback index.
- rd_data, out, 8, shadow[rd_addr], registered with 1-cycle latency.

Behaviour:
- Reset defaults (both shadow and active):
  - e0 = 00.
  - e1 = 80, e2 = 1F, e3 = E3.
  - e4 = FF, e5 = 00, e6 = E0, e7 = 92.
- Reset output values: wr_ack = 0, commit_pending = 0, rd_data = 00, FSM = IDLE, copy index = 0.
- FSM states:
  - IDLE: commit_req -> PENDING. A frame_start in the same cycle is NOT used; commit waits for the next frame_start.
  - PENDING: commit_pending = 1. frame_start -> COPY with idx = 0. Further commit_req is ignored (no queueing).
  - COPY: active[idx] <= shadow[idx] one entry per cycle; idx increments.
    - After idx = 7 is written -> IDLE; commit_pending drops the following cycle.
    - Copy takes exactly 8 cycles; frame_start during COPY is ignored.
- Write handshake:
  - While wr_req = 1 and state != COPY, the write is accepted. shadow[wr_addr] <= wr_data and wr_ack = 1 in the next cycle.
  - wr_ack then stays 0 for at least one cycle, even if wr_req remains high.
  - A back-to-back write needs wr_req low then high, or re-sampling after the ack.
  - In COPY, ack is withheld and the request stalls until IDLE.
  - Writes in PENDING go to shadow and are included in the pending commit.
- Simultaneous write and commit_req: both accepted. The write lands before any copy, since the copy starts only on a later frame_start.
- Active palette changes only in COPY; pal_active is register-driven with no combinational path from inputs.
- Readback: rd_data reflects the shadow as of the previous cycle's write.
- Reset mid-operation (PENDING or COPY): all state returns to defaults immediately; partial copies are discarded.

Optional Feature:
- Macro: PALETTE_BLINK_EN.
- Defined:
  - Adds a frame counter of width BLINK_DIV+1, incremented on each frame_start.
  - When the counter MSB = 1, pal_active entries 1-3 output 00 (icon blink). Active registers are unmodified.
  - Counter resets to 0.
- Undefined: no counter; pal_active is the active registers directly.

Decomposition:
- Package palette_pkg:
  - entry index constants: PAL_BLANK, PAL_ICON1..3, PAL_WORLD0..3.
  - default colour constants.
  - FSM state enum: IDLE, PENDING, COPY.
- No sub-module needed. The optional blink counter stays inline under the macro.

Test Plan:
- Reset: assert rst 2 cycles -> pal_active = 92E000FF_E31F8000, commit_pending = 0, wr_ack = 0.
- Write without commit: write e4 = 1C, then frame_start -> pal_active e4 stays FF; rd_addr = 4 gives rd_data = 1C.
- Write, commit_req, frame_start -> commit_pending high until 8 cycles after frame_start; e4 = 1C in active on COPY cycle 5; no other entries change.
- commit_req and frame_start in the same cycle -> no copy on that frame; copy on the next frame_start.
- wr_req held during COPY -> wr_ack only after return to IDLE; value committed only on the following commit.
- rst asserted at COPY cycle 3 -> active = defaults, FSM IDLE. With PALETTE_BLINK_EN, BLINK_DIV = 1: entries 1-3 read 00 on frames 2-3 and restore on frames 4-5.
